imem_loader: RTL and testbench

Instruction-memory loader: the write side of the program ROM. Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit MIPS instruction words, and writes them to consecutive word addresses of the instruction memory. Holds the CPU via `busy` while loading, so a program can be installed at run time instead of only from the `instruction.list` image at elaboration.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Loader bus: load control, byte-stream handshake and instruction-memory write port.
// Widths are fixed by the 1024-word program ROM: 11-bit word count, 32-bit byte address.
interface imem_loader_if;
    logic        start;
    logic [10:0] num_words;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, num_words, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );

    modport slave (
        input  start, num_words, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into words written to imem; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
// Latency: 4 accepted bytes + 1 write cycle per word; rx_ready decodes from state only, so stalls on rx_valid just hold.
module imem_loader #(
    parameter int DEPTH = 1024
) (
    input  logic         i_clk,
    input  logic         i_rst,
    imem_loader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;
    localparam state_t S_TAIL = S_CHECK;
`else
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [10:0]   r_cnt;
    logic [1:0]    r_bcnt;
    logic [31:0]   r_word;

    logic          w_rx_ready;
    logic          w_mem_we;
    logic          w_busy;
    logic          w_done;
    logic          w_hs;
    logic          w_last;
    logic [10:0]   w_clamped;
    logic [10:0]   w_idx_inc;

    assign w_clamped = (bus.num_words > 11'(DEPTH)) ? 11'(DEPTH) : bus.num_words;
    assign w_idx_inc = 11'(r_idx) + 11'd1;
    assign w_last    = (w_idx_inc == r_cnt);
    assign w_hs      = bus.rx_valid & w_rx_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rx_ready  = 1'b0;
        w_mem_we    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (w_clamped == 11'd0) ? S_TAIL : S_RECV;
                end
            end
            S_RECV: begin
                w_rx_ready = 1'b1;
                w_busy     = 1'b1;
                if (bus.rx_valid && r_bcnt == 2'd3) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_mem_we    = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = w_last ? S_TAIL : S_RECV;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_rx_ready = 1'b1;
                w_busy     = 1'b1;
                if (bus.rx_valid) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The byte counter wraps to 0 on the 4th byte, so each new word starts clean.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_bcnt <= '0;
            r_word <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_cnt  <= w_clamped;
                r_idx  <= '0;
                r_bcnt <= '0;
            end
            if (r_state == S_RECV && w_hs) begin
                r_word <= {r_word[23:0], bus.rx_data};
                r_bcnt <= r_bcnt + 2'd1;
            end
            if (r_state == S_WRITE && !w_last) begin
                r_idx <= r_idx + AW'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (r_state == S_RECV && w_hs) begin
            r_xor <= r_xor ^ bus.rx_data;
        end else if (r_state == S_CHECK && w_hs) begin
            r_err <= (bus.rx_data != r_xor);
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.rx_ready  = w_rx_ready;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_we ? {{(30-AW){1'b0}}, r_idx, 2'b00} : 32'd0;
    assign bus.mem_wdata = w_mem_we ? r_word : 32'd0;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized byte streams scored against a word-list model.
// Define IMEM_LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum build.
module tb_imem_loader;
    localparam int DEPTH = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic i_clk = 1'b0;
    logic i_rst;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int          n_total   = 0;
    int          n_bad     = 0;
    int          cyc       = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          start_cyc = 0;
    logic        done_err  = 1'b0;
    logic [7:0]  sent_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) begin
        if (bus.mem_we) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            chk("rdy_in_write", 64'(bus.rx_ready), 64'd0);
            chk("busy_in_write", 64'(bus.busy), 64'd1);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = bus.err;
            chk("busy_in_done", 64'(bus.busy), 64'd0);
        end
    end

    function automatic logic [7:0] xor_sent();
        logic [7:0] x = 8'd0;
        foreach (sent_q[i]) x ^= sent_q[i];
        return x;
    endfunction

    task automatic fill_random(input int nbytes);
        sent_q.delete();
        repeat (nbytes) sent_q.push_back(8'($urandom));
    endtask

    task automatic arm();
        tx_q = sent_q;
        if (CK == 1) tx_q.push_back(xor_sent());
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Called at posedge+1; returns one cycle later with start released.
    task automatic do_start(input logic [10:0] n);
        bus.start     = 1'b1;
        bus.num_words = n;
        start_cyc     = cyc;
        @(posedge i_clk); #1;
        bus.start     = 1'b0;
        bus.num_words = 11'($urandom);
    endtask

    task automatic send_stream(input int vmode, input int stop_after, input int budget);
        int  acc = 0;
        int  k   = 0;
        bit  ok;
        while (tx_q.size() > 0 && acc != stop_after && k < budget) begin
            case (vmode)
                0:       bus.rx_valid = 1'b1;
                1:       bus.rx_valid = (k % 2 == 0);
                default: bus.rx_valid = ($urandom_range(0, 99) < 60);
            endcase
            bus.rx_data = tx_q[0];
            @(negedge i_clk);
            ok = bus.rx_valid && bus.rx_ready;
            @(posedge i_clk); #1;
            if (ok) begin
                void'(tx_q.pop_front());
                acc++;
            end
            k++;
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        chk("tx_budget", 64'(k < budget), 64'd1);
    endtask

    task automatic wait_done(input int n0, input int budget);
        int k = 0;
        while (done_cnt == n0 && k < budget) begin
            @(posedge i_clk);
            k++;
        end
        repeat (2) @(posedge i_clk);
        #1;
        chk("done_pulses", 64'(done_cnt - n0), 64'd1);
    endtask

    task automatic cmp_writes(input string tag, input int n_req);
        int n_exp = (n_req > DEPTH) ? DEPTH : n_req;
        int nbad  = 0;
        chk({tag, "_cnt"}, 64'(wr_addr_q.size()), 64'(n_exp));
        for (int i = 0; i < wr_addr_q.size() && i < n_exp; i++) begin
            logic [31:0] w;
            w = {sent_q[4*i], sent_q[4*i+1], sent_q[4*i+2], sent_q[4*i+3]};
            if (wr_data_q[i] !== w || wr_addr_q[i] !== 32'(4*i)) nbad++;
        end
        chk({tag, "_words"}, 64'(nbad), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int n0;
        int n;
        i_rst         = 1'b1;
        bus.start     = 1'b0;
        bus.num_words = 11'd0;
        bus.rx_data   = 8'd0;
        bus.rx_valid  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Two words, rx_valid held high.
        sent_q = {8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        arm();
        n0 = done_cnt;
        do_start(11'd2);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        chk("t1_rx_ready", 64'(bus.rx_ready), 64'd1);
        send_stream(0, -1, 200);
        wait_done(n0, 100);
        cmp_writes("t1", 2);
        chk("t1_w0", 64'(wr_data_q[0]), 64'h20080005);
        chk("t1_a1", 64'(wr_addr_q[1]), 64'h4);
        chk("t1_w1", 64'(wr_data_q[1]), 64'h0);
        chk("t1_latency", 64'(done_cyc - start_cyc), 64'(11 + CK));
        chk("t1_err", 64'(done_err), 64'd0);

        // Same stream, rx_valid toggling.
        arm();
        n0 = done_cnt;
        do_start(11'd2);
        send_stream(1, -1, 200);
        wait_done(n0, 100);
        cmp_writes("t2", 2);
        chk("t2_err", 64'(done_err), 64'd0);

        // Zero-length load.
        sent_q.delete();
        arm();
        n0 = done_cnt;
        do_start(11'd0);
        send_stream(0, -1, 50);
        wait_done(n0, 50);
        chk("t3_no_write", 64'(wr_addr_q.size()), 64'd0);
        chk("t3_latency", 64'(done_cyc - start_cyc), 64'(1 + CK));

        // Oversized count clamps to DEPTH.
        fill_random(4 * DEPTH);
        arm();
        n0 = done_cnt;
        do_start(11'd1500);
        send_stream(0, -1, 6000);
        wait_done(n0, 200);
        cmp_writes("t4", 1500);
        chk("t4_last_addr", 64'(wr_addr_q[wr_addr_q.size()-1]), 64'hFFC);

        // Reset after six bytes.
        sent_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        arm();
        n0 = done_cnt;
        do_start(11'd2);
        send_stream(0, 6, 100);
        i_rst = 1'b1;
        #1;
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_rx_ready", 64'(bus.rx_ready), 64'd0);
        chk("t5_mem_we", 64'(bus.mem_we), 64'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        chk("t5_nwr", 64'(wr_addr_q.size()), 64'd1);
        chk("t5_w0", 64'(wr_data_q[0]), 64'hDEADBEEF);
        chk("t5_a0", 64'(wr_addr_q[0]), 64'h0);
        chk("t5_no_done", 64'(done_cnt - n0), 64'd0);

        // Random loads with random rx_valid gaps.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 8);
            fill_random(4 * n);
            arm();
            n0 = done_cnt;
            do_start(11'(n));
            send_stream(2, -1, 400);
            wait_done(n0, 100);
            cmp_writes("rnd", n);
            chk("rnd_err", 64'(done_err), 64'd0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good, then bad, then cleared by the next start.
        sent_q = {8'h12, 8'h34, 8'h56, 8'h78};
        arm();
        n0 = done_cnt;
        do_start(11'd1);
        send_stream(0, -1, 50);
        wait_done(n0, 50);
        chk("ck_good_err", 64'(done_err), 64'd0);

        arm();
        void'(tx_q.pop_back());
        tx_q.push_back(8'h09);
        n0 = done_cnt;
        do_start(11'd1);
        send_stream(0, -1, 50);
        wait_done(n0, 50);
        chk("ck_bad_err", 64'(done_err), 64'd1);
        chk("ck_bad_held", 64'(bus.err), 64'd1);

        arm();
        n0 = done_cnt;
        do_start(11'd1);
        chk("ck_err_cleared", 64'(bus.err), 64'd0);
        send_stream(0, -1, 50);
        wait_done(n0, 50);
        chk("ck_after_err", 64'(done_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
